// File: rtl/tcam_priority_search.sv
// Ternary CAM with stored per-entry masks, valid bits, a global search mask
// and a two-stage registered search pipeline with a lowest-index priority encoder.
module tcam_priority_search #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_word,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  inv_en,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic                  flush,
  input  logic                  search_valid,
  input  logic [DATA_WIDTH-1:0] search_word,
  input  logic [DATA_WIDTH-1:0] search_mask,
  output logic                  result_valid,
  output logic [DEPTH-1:0]      match_vector,
  output logic                  match_any,
  output logic                  match_multi,
  output logic [ADDR_WIDTH-1:0] match_addr
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] word_q, word_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DEPTH-1:0]                 valid_q, valid_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DEPTH-1:0]      s1_vec_q, s1_vec_d;
  logic [DEPTH-1:0]      cmp_vec;

  logic                  result_valid_q, result_valid_d;
  logic [DEPTH-1:0]      match_vector_q, match_vector_d;
  logic                  match_any_q, match_any_d;
  logic                  match_multi_q, match_multi_d;
  logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
  logic                  seen_c;

  // Storage update: write wins over invalidate, which wins over flush
  always_comb begin
    word_d  = word_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (flush) valid_d = '0;
    if (inv_en) valid_d[inv_addr] = 1'b0;
    if (wr_en) begin
      word_d[wr_addr]  = wr_word;
      mask_d[wr_addr]  = wr_mask;
      valid_d[wr_addr] = 1'b1;
    end
  end

  // Stage 1: ternary compare against pre-edge storage contents
  always_comb begin
    cmp_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cmp_vec[i] = valid_q[i] &&
                   (((word_q[i] ^ search_word) & ~mask_q[i] & ~search_mask) == '0);
    end
    s1_valid_d = search_valid;
    s1_vec_d   = search_valid ? cmp_vec : '0;
  end

  // Stage 2: lowest-index encode, any and multi-match; zeros when idle
  always_comb begin
    result_valid_d = s1_valid_q;
    match_vector_d = '0;
    match_any_d    = 1'b0;
    match_multi_d  = 1'b0;
    match_addr_d   = '0;
    seen_c         = 1'b0;
    if (s1_valid_q) begin
      match_vector_d = s1_vec_q;
      match_any_d    = |s1_vec_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (s1_vec_q[i]) begin
          if (seen_c) match_multi_d = 1'b1;
          else        match_addr_d  = ADDR_WIDTH'(i);
          seen_c = 1'b1;
        end
      end
    end
  end

  // Word and mask storage carry no reset; writes are blocked during reset
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= word_d;
      mask_q <= mask_d;
    end
  end

  // Valid bits and pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q        <= '0;
      s1_valid_q     <= 1'b0;
      s1_vec_q       <= '0;
      result_valid_q <= 1'b0;
      match_vector_q <= '0;
      match_any_q    <= 1'b0;
      match_multi_q  <= 1'b0;
      match_addr_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      s1_valid_q     <= s1_valid_d;
      s1_vec_q       <= s1_vec_d;
      result_valid_q <= result_valid_d;
      match_vector_q <= match_vector_d;
      match_any_q    <= match_any_d;
      match_multi_q  <= match_multi_d;
      match_addr_q   <= match_addr_d;
    end
  end

  assign result_valid = result_valid_q;
  assign match_vector = match_vector_q;
  assign match_any    = match_any_q;
  assign match_multi  = match_multi_q;
  assign match_addr   = match_addr_q;

endmodule

// File: tb/tb_tcam_priority_search.sv
// Directed, table-driven bench for tcam_priority_search (8x8 default).
module tb_tcam_priority_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_word;
  logic [7:0] wr_mask;
  logic       inv_en;
  logic [2:0] inv_addr;
  logic       flush;
  logic       search_valid;
  logic [7:0] search_word;
  logic [7:0] search_mask;
  logic       result_valid;
  logic [7:0] match_vector;
  logic       match_any;
  logic       match_multi;
  logic [2:0] match_addr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] sm;
    logic [7:0] vec;
    logic       any;
    logic       multi;
    logic [2:0] addr;
  } vec_t;

  tcam_priority_search dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word), .wr_mask(wr_mask),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
    .search_valid(search_valid), .search_word(search_word), .search_mask(search_mask),
    .result_valid(result_valid), .match_vector(match_vector), .match_any(match_any),
    .match_multi(match_multi), .match_addr(match_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_word = '0; wr_mask = '0;
    inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
    search_valid = 1'b0; search_word = '0; search_mask = '0;
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] evec,
                       input logic eany, input logic emulti, input logic [2:0] eaddr);
    logic [13:0] got, exp;
    got = {result_valid, match_vector, match_any, match_multi, match_addr};
    exp = {ev, evec, eany, emulti, eaddr};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got valid=%b vec=%h any=%b multi=%b addr=%0d, want valid=%b vec=%h any=%b multi=%b addr=%0d",
               name, result_valid, match_vector, match_any, match_multi, match_addr,
               ev, evec, eany, emulti, eaddr);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] w, input logic [7:0] m);
    wr_en = 1'b1; wr_addr = a; wr_word = w; wr_mask = m;
    step();
    wr_en = 1'b0;
  endtask

  task automatic set_search(input logic [7:0] w, input logic [7:0] m);
    search_valid = 1'b1; search_word = w; search_mask = m;
  endtask

  // Issue the table back-to-back; each result lands two edges after issue
  task automatic run_table(input string name, input vec_t t[$]);
    for (int i = 0; i <= t.size(); i++) begin
      if (i < t.size()) set_search(t[i].sw, t[i].sm);
      else search_valid = 1'b0;
      step();
      if (i >= 1)
        check($sformatf("%s[%0d]", name, i - 1), 1'b1, t[i-1].vec, t[i-1].any,
              t[i-1].multi, t[i-1].addr);
    end
    step();
    check({name, "_idle"}, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    vec_t t_empty[$];
    vec_t t_basic[$];
    vec_t t_multi[$];
    vec_t t_gmask[$];
    vec_t t_flush[$];

    t_empty = '{'{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0}};
    t_basic = '{'{8'h10, 8'h00, 8'h10, 1'b1, 1'b0, 3'd4},
                '{8'h11, 8'h00, 8'h10, 1'b1, 1'b0, 3'd4},
                '{8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 3'd0},
                '{8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0}};
    t_multi = '{'{8'h02, 8'h00, 8'h06, 1'b1, 1'b1, 3'd1},
                '{8'h77, 8'h00, 8'h04, 1'b1, 1'b0, 3'd2}};
    t_gmask = '{'{8'h03, 8'h02, 8'h01, 1'b1, 1'b0, 3'd0},
                '{8'h00, 8'hFF, 8'h13, 1'b1, 1'b1, 3'd0},
                '{8'h12, 8'h03, 8'h10, 1'b1, 1'b0, 3'd4}};
    t_flush = '{'{8'h55, 8'h00, 8'h20, 1'b1, 1'b0, 3'd5},
                '{8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0}};

    idle();
    rst = 1'b0;
    set_search(8'h00, 8'hFF);
    wr_en = 1'b1; wr_addr = 3'd7; wr_word = 8'hAA;
    step(); step(); step();
    check("reset_outputs", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    idle();
    rst = 1'b1;
    step();
    check("after_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);

    run_table("empty", t_empty);

    do_write(3'd0, 8'h01, 8'h00);
    do_write(3'd1, 8'h02, 8'h00);
    do_write(3'd4, 8'h11, 8'h01);
    run_table("basic", t_basic);

    do_write(3'd2, 8'h00, 8'hFF);
    run_table("multi", t_multi);

    inv_en = 1'b1; inv_addr = 3'd2;
    step();
    inv_en = 1'b0;
    run_table("gmask", t_gmask);

    // Same-edge write is invisible to the search sampled on that edge
    wr_en = 1'b1; wr_addr = 3'd3; wr_word = 8'h08; wr_mask = 8'h00;
    set_search(8'h08, 8'h00);
    step();
    wr_en = 1'b0;
    step();
    check("same_edge_wr", 1'b1, 8'h00, 1'b0, 1'b0, 3'd0);
    search_valid = 1'b0;
    step();
    check("next_cycle_wr", 1'b1, 8'h08, 1'b1, 1'b0, 3'd3);

    // Flush with a concurrent write keeps only the written entry
    flush = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_word = 8'h55; wr_mask = 8'h00;
    step();
    idle();
    run_table("flush", t_flush);

    // Write beats invalidate on the same entry
    inv_en = 1'b1; inv_addr = 3'd5;
    wr_en = 1'b1; wr_addr = 3'd5; wr_word = 8'h66; wr_mask = 8'h00;
    step();
    idle();
    set_search(8'h66, 8'h00);
    step();
    search_valid = 1'b0;
    step();
    check("wr_over_inv", 1'b1, 8'h20, 1'b1, 1'b0, 3'd5);

    // Search in stage 1 keeps its match despite a later invalidate
    set_search(8'h66, 8'h00);
    step();
    search_valid = 1'b0;
    inv_en = 1'b1; inv_addr = 3'd5;
    step();
    inv_en = 1'b0;
    check("inflight_keeps", 1'b1, 8'h20, 1'b1, 1'b0, 3'd5);
    set_search(8'h66, 8'h00);
    step();
    search_valid = 1'b0;
    step();
    check("post_inv", 1'b1, 8'h00, 1'b0, 1'b0, 3'd0);

    // Reset one edge after a search discards it and clears all entries
    do_write(3'd6, 8'h3C, 8'h00);
    set_search(8'h3C, 8'h00);
    step();
    search_valid = 1'b0;
    rst = 1'b0;
    step();
    check("rst_inflight_a", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    rst = 1'b1;
    step();
    check("rst_inflight_b", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    set_search(8'h00, 8'hFF);
    step();
    search_valid = 1'b0;
    step();
    check("all_invalid", 1'b1, 8'h00, 1'b0, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcam_priority_search.md
# tcam_priority_search

Parametrised ternary CAM with per-entry stored don't-care masks, per-entry valid bits, a global search mask and a registered priority encoder. It replaces the fixed 8x8 CAM wrapper: binary write addressing, single-entry invalidate and flush, a one-search-per-cycle two-stage pipeline, and both a decoded match vector and an encoded lowest-index match address. It sits between the lookup-request logic and the consumers of match results.

## Interface

- DATA_WIDTH, 8, stored/search word width (>=1)
- DEPTH, 8, number of entries (power of two, >=2)
- ADDR_WIDTH, $clog2(DEPTH), entry address width

- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low (0 = reset)
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_WIDTH  entry to write
- wr_word  input  DATA_WIDTH  value to store
- wr_mask  input  DATA_WIDTH  stored don't-care bits (1 = bit ignored for this entry)
- inv_en  input  1  invalidate strobe
- inv_addr  input  ADDR_WIDTH  entry to invalidate
- flush  input  1  invalidate all entries
- search_valid  input  1  search request, accepted every cycle it is high
- search_word  input  DATA_WIDTH  key
- search_mask  input  DATA_WIDTH  global don't-care for this search (1 = bit ignored)
- result_valid  output  1  result outputs valid this cycle
- match_vector  output  DEPTH  bit i = entry i matched
- match_any  output  1  OR of match_vector
- match_multi  output  1  two or more entries matched
- match_addr  output  ADDR_WIDTH  lowest matching index; 0 when match_any=0

## Operation

- Storage: word[DEPTH], mask[DEPTH], valid[DEPTH]. Only valid is reset; word and mask are left uninitialised.
- Entry i matches when valid[i]=1 and ((word[i] ^ search_word) & ~mask[i] & ~search_mask) == 0.
- Write: wr_en=1 at an edge stores wr_word and wr_mask at wr_addr and sets valid[wr_addr]=1.
- inv_en=1 clears valid[inv_addr]. flush=1 clears all valid bits.
- Valid-bit update priority within one edge: write > inv_en > flush, per entry. A write to the invalidated address, or during a flush, leaves that entry valid.
- Stage 1: on an edge with search_valid=1, compare against the storage contents present before that edge. This is read-before-write: a same-edge write is not seen. Register the match vector and s1_valid.
- Stage 2: register the match vector, the priority-encoded lowest set index, OR, and multi-match (popcount >= 2). result_valid <= s1_valid.
- When result_valid=0, every result output is driven to 0.
- Entries are independent, and there are no restrictions on back-to-back operations.

## Timing

- Reset (rst=0 at an edge): valid cleared, s1_valid=0, result_valid=0, and match_vector, match_any, match_multi and match_addr all 0 from the next cycle. Write, invalidate, flush and search are all ignored while rst=0.
- Reset mid-operation: in-flight searches are discarded, and no result_valid pulse is produced for them.
- Latency: a search sampled at edge k produces outputs valid in the cycle after edge k+1. Throughput is 1 search/clock.
- A write at edge k is visible to a search sampled at edge k+1 or later.
- An invalidate or flush at edge k suppresses that entry for searches sampled at edge k+1 or later. Searches already in stage 1 keep their match.
- Address wrap: none. All addresses are in range by construction of power-of-two DEPTH.

## Test plan

- Reset, then search 0x00 with search_mask 0x00 -> two cycles later result_valid=1, match_vector=0x00, match_any=0, match_addr=0, match_multi=0.
- Write entry0=0x01 (mask 0x00), entry1=0x02, entry4=0x11 (mask 0x01). Then search back-to-back 0x10, 0x11, 0x01, 0x33 -> consecutive results with vectors 0x10, 0x10, 0x01, 0x00 and addresses 4, 4, 0, 0. result_valid stays high for four cycles.
- Add entry2=0x00 (mask 0xFF), then search 0x02 -> match_vector=0x06, match_addr=1, match_multi=1.
- Global mask: with entry2 invalidated via inv_en, search 0x03 with search_mask 0x02 -> match_vector=0x01, match_addr=0.
- Same-edge write/search: write entry3=0x08 and search 0x08 on the same edge -> bit 3 clear. Repeat the search next cycle -> bit 3 set.
- Flush together with a write to entry5=0x55, then search 0x55 and 0x01 -> 0x20 and 0x00.
- Issue a search, then rst=0 on the next edge -> no result_valid pulse, and all entries invalid afterwards.
